// File: rtl/unpack_gearbox.sv
// unpack_gearbox: splits ISIZE-bit beats into OSIZE-bit pixels, MSB first.
// Leftover bits carry across beat boundaries in a left-justified bit buffer.
// A frame-end flush emits the final partial pixel with a byte mask, and
// ialign throws away whatever residue is buffered.
module unpack_gearbox #(
    parameter int ISIZE = 256,
    parameter int OSIZE = 24,
    parameter int CW    = $clog2(ISIZE + OSIZE) + 1
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               ialign,
    input  logic               ivalid,
    output logic               iready,
    input  logic [ISIZE-1:0]   idata,
    input  logic               ilast,
    output logic               ovalid,
    input  logic               oready,
    output logic [OSIZE-1:0]   odata,
    output logic [OSIZE/8-1:0] omask,
    output logic               olast
);

    localparam int BW = ISIZE + OSIZE - 1;
    localparam int MW = OSIZE / 8;
    localparam logic [CW-1:0] OSZ = CW'(OSIZE);
    localparam logic [CW-1:0] ISZ = CW'(ISIZE);

    logic [BW-1:0] bit_buf;
    logic [CW-1:0] cnt;
    logic          lastp;

    logic accept;
    logic out_free;
    logic take_full;
    logic take_flush;
    logic load;

    // Place a new beat directly below the c bits already held.
    function automatic logic [BW-1:0] append(input logic [BW-1:0] b,
                                             input logic [ISIZE-1:0] d,
                                             input logic [CW-1:0] c);
        logic [BW-1:0] ext;
        ext = {d, {(OSIZE-1){1'b0}}};
        return b | (ext >> c);
    endfunction

    // Byte mask for a partial pixel of c bits: top c/8 mask bits set.
    function automatic logic [MW-1:0] flush_mask(input logic [CW-1:0] c);
        return ~({MW{1'b1}} >> c[CW-1:3]);
    endfunction

    // Ready depends on registered state only; accept and extract are
    // mutually exclusive because one needs cnt < OSIZE and the other cnt >= OSIZE.
    assign iready     = (cnt < OSZ) && !lastp;
    assign accept     = ivalid && iready && !ialign;
    assign out_free   = !ovalid || oready;
    assign take_full  = (cnt >= OSZ);
    assign take_flush = lastp && (cnt != '0) && !take_full;
    assign load       = out_free && !ialign && (take_full || take_flush);

    // Bit buffer, fill count and pending-flush flag.
    always_ff @(posedge clock) begin
        if (rst) begin
            bit_buf <= '0;
            cnt     <= '0;
            lastp   <= 1'b0;
        end else if (ialign) begin
            bit_buf <= '0;
            cnt     <= '0;
            lastp   <= 1'b0;
        end else if (accept) begin
            bit_buf <= append(bit_buf, idata, cnt);
            cnt     <= cnt + ISZ;
            lastp   <= ilast;
        end else if (load) begin
            if (take_full) begin
                bit_buf <= bit_buf << OSIZE;
                cnt     <= cnt - OSZ;
                if (lastp && (cnt == OSZ)) lastp <= 1'b0;
            end else begin
                bit_buf <= '0;
                cnt     <= '0;
                lastp   <= 1'b0;
            end
        end
    end

    // Output register: loads a full or flush pixel, holds while stalled.
    always_ff @(posedge clock) begin
        if (rst) begin
            ovalid <= 1'b0;
            odata  <= '0;
            omask  <= '0;
            olast  <= 1'b0;
        end else if (load) begin
            ovalid <= 1'b1;
            odata  <= bit_buf[BW-1 -: OSIZE];
            omask  <= take_full ? {MW{1'b1}} : flush_mask(cnt);
            olast  <= take_full ? (lastp && (cnt == OSZ)) : 1'b1;
        end else if (ovalid && oready) begin
            ovalid <= 1'b0;
        end
    end

endmodule
